prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles big-endian 16-bit words from a byte
// stream, writes them to instruction memory and holds the CPU until complete.
module prog_loader #(
    parameter int IM_SIZE   = 8,
    parameter int WORD_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IM_SIZE:0]     load_len,
    input  logic                 abort,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 imem_we,
    output logic [IM_SIZE-1:0]   imem_addr,
    output logic [WORD_BITS-1:0] imem_wdata,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HI     = 3'd1,
        LO     = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [IM_SIZE:0]     LEN_ZERO  = {(IM_SIZE+1){1'b0}};
    localparam logic [IM_SIZE:0]     LEN_ONE   = (IM_SIZE+1)'(1);
    localparam logic [IM_SIZE:0]     LEN_MAX   = {1'b1, {IM_SIZE{1'b0}}};
    localparam logic [IM_SIZE-1:0]   ADDR_ZERO = {IM_SIZE{1'b0}};
    localparam logic [IM_SIZE-1:0]   ADDR_ONE  = IM_SIZE'(1);
    localparam logic [WORD_BITS-1:0] DATA_ZERO = {WORD_BITS{1'b0}};

    state_t                 state_r, state_s;
    logic [IM_SIZE:0]       len_r, len_s;
    logic [IM_SIZE:0]       cnt_r, cnt_s, cnt_inc_s;
    logic [IM_SIZE-1:0]     addr_r, addr_s;
    logic [WORD_BITS-1:0]   data_r, data_s;
    logic                   err_r, err_s;
    logic                   hold_r, hold_s;
    logic                   we_r, ready_r, busy_r, done_r;
    logic                   len_ok_s, xfer_s;

    // abort pre-empts a byte offered in the same cycle, so the handshake is gated by it
    assign byte_ready = ready_r & ~abort;
    assign xfer_s     = byte_valid & ready_r & ~abort;
    assign len_ok_s   = (load_len != LEN_ZERO) && (load_len <= LEN_MAX);
    assign cnt_inc_s  = cnt_r + LEN_ONE;

    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = data_r;
    assign cpu_hold   = hold_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

    // Next-state and next-datapath decode
    always_comb begin
        state_s = state_r;
        len_s   = len_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        data_s  = data_r;
        err_s   = err_r;
        hold_s  = hold_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (len_ok_s) begin
                        len_s   = load_len;
                        cnt_s   = LEN_ZERO;
                        addr_s  = ADDR_ZERO;
                        err_s   = 1'b0;
                        hold_s  = 1'b1;
                        state_s = HI;
                    end else begin
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            HI: begin
                if (abort) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (xfer_s) begin
                    data_s  = {byte_in, data_r[WORD_BITS-9:0]};
                    state_s = LO;
                end else begin
                    state_s = HI;
                end
            end
            LO: begin
                if (abort) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (xfer_s) begin
                    data_s  = {data_r[WORD_BITS-1:8], byte_in};
                    state_s = WRITE;
                end else begin
                    state_s = LO;
                end
            end
            WRITE: begin
                // the strobe for this word is already on the port; abort only stops what follows
                cnt_s = cnt_inc_s;
                if (abort) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else if (cnt_inc_s == len_r) begin
                    hold_s  = 1'b0;
                    state_s = FINISH;
                end else begin
                    addr_s  = addr_r + ADDR_ONE;
                    state_s = HI;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (outputs track the state being entered)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            len_r   <= LEN_ZERO;
            cnt_r   <= LEN_ZERO;
            addr_r  <= ADDR_ZERO;
            data_r  <= DATA_ZERO;
            err_r   <= 1'b0;
            hold_r  <= 1'b1;
            we_r    <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            err_r   <= err_s;
            hold_r  <= hold_s;
            we_r    <= (state_s == WRITE);
            ready_r <= (state_s == HI) || (state_s == LO);
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == FINISH);
        end
    end

endmodule
